// File: rtl/cv32e41p_pkg.sv
// Shared type and constant definitions for the cv32e41p fetch path.
// Holds the instruction realigner state encoding and PC step sizes.
// Imported by the fetch-stage modules; contains no logic.
package cv32e41p_pkg;

  // Realigner position relative to the current fetch word
  typedef enum logic [1:0] {
    ALIGNED32         = 2'd0,  // next instruction starts at the word's low half
    MISALIGNED32      = 2'd1,  // low half of a straddling 32-bit instr is in instr_h_q
    MISALIGNED16      = 2'd2,  // a complete compressed instr is in instr_h_q
    BRANCH_MISALIGNED = 2'd3   // redirected to word address + 2
  } realign_state_e;

  localparam logic [31:0] INSTR_STEP_16 = 32'd2;
  localparam logic [31:0] INSTR_STEP_32 = 32'd4;

endpackage

// File: rtl/cv32e41p_instr_realign.sv
// Extracts one 16/32-bit instruction per accept from word-aligned fetch data and tracks the IF PC.
// Latency: zero, outputs are combinational from state and the current fetch word.
// Backpressure: a fetch word is consumed only while fetch_ready_o is high; optional hwlp redirect via CV32E41P_REALIGN_HWLP_EN.
module cv32e41p_instr_realign
  import cv32e41p_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        if_valid_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_update_pc_i,
  input  logic [31:0] hwlp_addr_i,
  output logic [31:0] instr_aligned_o,
  output logic        instr_valid_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o
);

  realign_state_e state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [15:0]    instr_h_q;
  logic           store_h;
  logic           accept;
  logic           upper_is_32;
  realign_state_e upper_state;

  // The upper half of the fetch word decides where a stored half leaves us
  assign upper_is_32 = (fetch_rdata_i[17:16] == 2'b11);
  assign upper_state = upper_is_32 ? MISALIGNED32 : MISALIGNED16;

  assign pc_o               = pc_q;
  assign instr_compressed_o = (instr_aligned_o[1:0] != 2'b11);
  assign accept             = instr_valid_o & if_valid_i;

  // Present the instruction for the current state; a branch kills the cycle
  always_comb begin
    instr_aligned_o = fetch_rdata_i;
    instr_valid_o   = fetch_valid_i;
    fetch_ready_o   = 1'b1;
    case (state_q)
      ALIGNED32: ;
      MISALIGNED32: instr_aligned_o = {fetch_rdata_i[15:0], instr_h_q};
      MISALIGNED16: begin
        instr_aligned_o = {16'h0, instr_h_q};
        instr_valid_o   = 1'b1;
        fetch_ready_o   = 1'b0;
      end
      BRANCH_MISALIGNED: begin
        if (upper_is_32) instr_valid_o = 1'b0;
        else             instr_aligned_o = {16'h0, fetch_rdata_i[31:16]};
      end
    endcase
    if (branch_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b0;
    end
  end

`ifdef CV32E41P_REALIGN_HWLP_EN
  logic        hwlp_pend_q, hwlp_pend_d;
  logic [31:0] hwlp_addr_q, hwlp_addr_d;
  logic [31:0] hwlp_tgt;
  assign hwlp_tgt = hwlp_update_pc_i ? hwlp_addr_i : hwlp_addr_q;
`else
  logic unused_hwlp;
  assign unused_hwlp = ^{hwlp_update_pc_i, hwlp_addr_i};
`endif

  // Sequential advance, then hardware-loop redirect, then branch (highest priority)
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    store_h = 1'b0;
`ifdef CV32E41P_REALIGN_HWLP_EN
    hwlp_pend_d = hwlp_pend_q;
    hwlp_addr_d = hwlp_addr_q;
`endif
    case (state_q)
      ALIGNED32: begin
        if (accept) begin
          if (instr_compressed_o) begin
            pc_d    = pc_q + INSTR_STEP_16;
            store_h = 1'b1;
            state_d = upper_state;
          end else begin
            pc_d = pc_q + INSTR_STEP_32;
          end
        end
      end
      MISALIGNED32: begin
        if (accept) begin
          pc_d    = pc_q + INSTR_STEP_32;
          store_h = 1'b1;
          state_d = upper_state;
        end
      end
      MISALIGNED16: begin
        if (accept) begin
          pc_d    = pc_q + INSTR_STEP_16;
          state_d = ALIGNED32;
        end
      end
      BRANCH_MISALIGNED: begin
        if (upper_is_32) begin
          if (fetch_valid_i) begin
            store_h = 1'b1;
            state_d = MISALIGNED32;
          end
        end else if (accept) begin
          pc_d    = pc_q + INSTR_STEP_16;
          state_d = ALIGNED32;
        end
      end
    endcase
`ifdef CV32E41P_REALIGN_HWLP_EN
    if (accept && (hwlp_update_pc_i || hwlp_pend_q)) begin
      pc_d        = hwlp_tgt;
      state_d     = hwlp_tgt[1] ? BRANCH_MISALIGNED : ALIGNED32;
      store_h     = 1'b0;
      hwlp_pend_d = 1'b0;
    end else if (hwlp_update_pc_i) begin
      hwlp_pend_d = 1'b1;
      hwlp_addr_d = hwlp_addr_i;
    end
`endif
    if (branch_i) begin
      pc_d    = branch_addr_i;
      state_d = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED32;
      store_h = 1'b0;
`ifdef CV32E41P_REALIGN_HWLP_EN
      hwlp_pend_d = 1'b0;
`endif
    end
  end

  // State, PC and stored upper half
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ALIGNED32;
      pc_q      <= BOOT_PC;
      instr_h_q <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (store_h) instr_h_q <= fetch_rdata_i[31:16];
    end
  end

`ifdef CV32E41P_REALIGN_HWLP_EN
  // Deferred hardware-loop target waiting for the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwlp_pend_q <= 1'b0;
      hwlp_addr_q <= 32'h0;
    end else begin
      hwlp_pend_q <= hwlp_pend_d;
      hwlp_addr_q <= hwlp_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_cv32e41p_instr_realign.sv
// Self-checking bench for cv32e41p_instr_realign: directed scenarios plus a
// randomized run against a halfword-memory / fetch-cursor reference model.
// Hardware-loop expectations follow CV32E41P_REALIGN_HWLP_EN.
module tb_cv32e41p_instr_realign;

`ifdef CV32E41P_REALIGN_HWLP_EN
  localparam bit HWLP_EN = 1'b1;
`else
  localparam bit HWLP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_rdata_i = 32'h0;
  logic        fetch_ready_o;
  logic        if_valid_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        hwlp_update_pc_i = 1'b0;
  logic [31:0] hwlp_addr_i = 32'h0;
  logic [31:0] instr_aligned_o;
  logic        instr_valid_o;
  logic        instr_compressed_o;
  logic [31:0] pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [512];

  always #5 clk = ~clk;

  cv32e41p_instr_realign #(.BOOT_PC(32'h80)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_rdata_i     (fetch_rdata_i),
    .fetch_ready_o     (fetch_ready_o),
    .if_valid_i        (if_valid_i),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .hwlp_update_pc_i  (hwlp_update_pc_i),
    .hwlp_addr_i       (hwlp_addr_i),
    .instr_aligned_o   (instr_aligned_o),
    .instr_valid_o     (instr_valid_o),
    .instr_compressed_o(instr_compressed_o),
    .pc_o              (pc_o)
  );

  function automatic logic [15:0] hw(input logic [31:0] a);
    return mem[a[9:1]];
  endfunction

  task automatic drive(input logic fv, input logic [31:0] rd, input logic iv,
                       input logic br, input logic [31:0] ba,
                       input logic hu, input logic [31:0] ha);
    @(negedge clk);
    fetch_valid_i = fv; fetch_rdata_i = rd; if_valid_i = iv;
    branch_i = br; branch_addr_i = ba; hwlp_update_pc_i = hu; hwlp_addr_i = ha;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_valid_i = 0; if_valid_i = 0; branch_i = 0; hwlp_update_pc_i = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; fetch_valid_i = 0; if_valid_i = 0; branch_i = 0; hwlp_update_pc_i = 0;
    #1;
    n_tests++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h80); end
    n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o); end
    n_tests++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); end
    @(negedge clk); rst = 1'b0;
    // Park a compressed half, then reset asynchronously mid-cycle
    drive(1, 32'h4585_4501, 1, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL pre_areset_valid got=%b exp=1", instr_valid_o); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL areset_pc got=%h exp=%h", pc_o, 32'h80); end
    n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", instr_valid_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_aligned32();
    do_reset();
    drive(1, 32'h0000_0013, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o !== 32'h13) begin n_fail++; $display("FAIL al32_instr got=%h exp=%h", instr_aligned_o, 32'h13); end
    n_tests++; if (instr_valid_o !== 1'b1 || instr_compressed_o !== 1'b0) begin n_fail++; $display("FAIL al32_flags got=%b%b exp=10", instr_valid_o, instr_compressed_o); end
    n_tests++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL al32_pc0 got=%h exp=%h", pc_o, 32'h80); end
    drive(1, 32'h0000_0013, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h84) begin n_fail++; $display("FAIL al32_pc1 got=%h exp=%h", pc_o, 32'h84); end
    n_tests++; if (instr_aligned_o !== 32'h13) begin n_fail++; $display("FAIL al32_stay got=%h exp=%h", instr_aligned_o, 32'h13); end
  endtask

  task automatic test_straddle();
    do_reset();
    drive(1, 32'h0513_4501, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o[15:0] !== 16'h4501 || instr_compressed_o !== 1'b1) begin n_fail++; $display("FAIL strad_c got=%h/%b exp=4501/1", instr_aligned_o[15:0], instr_compressed_o); end
    drive(0, $urandom, 1, 0, 0, 0, 0);
    n_tests++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h82) begin n_fail++; $display("FAIL strad_wait got=%b/%h exp=0/82", instr_valid_o, pc_o); end
    drive(1, 32'hABCD_0000, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o !== 32'h0000_0513 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL strad_instr got=%h/%b exp=00000513/1", instr_aligned_o, instr_valid_o); end
    n_tests++; if (instr_compressed_o !== 1'b0 || pc_o !== 32'h82) begin n_fail++; $display("FAIL strad_pc got=%b/%h exp=0/82", instr_compressed_o, pc_o); end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h86) begin n_fail++; $display("FAIL strad_next got=%h exp=86", pc_o); end
  endtask

  task automatic test_two_compressed();
    do_reset();
    drive(1, 32'h4585_4501, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o[15:0] !== 16'h4501 || fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL c2_first got=%h/%b exp=4501/1", instr_aligned_o[15:0], fetch_ready_o); end
    drive(0, 32'h0, 1, 0, 0, 0, 0);
    n_tests++; if (instr_valid_o !== 1'b1 || fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL c2_flow got=%b/%b exp=1/0", instr_valid_o, fetch_ready_o); end
    n_tests++; if (instr_aligned_o[15:0] !== 16'h4585 || pc_o !== 32'h82) begin n_fail++; $display("FAIL c2_second got=%h/%h exp=4585/82", instr_aligned_o[15:0], pc_o); end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h84) begin n_fail++; $display("FAIL c2_next got=%h exp=84", pc_o); end
  endtask

  task automatic test_branch_misaligned();
    do_reset();
    drive(1, 32'h1111_2222, 1, 1, 32'h102, 0, 0);
    n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL br_cycle got=%b/%b exp=0/0", instr_valid_o, fetch_ready_o); end
    drive(1, 32'h0613_1234, 1, 0, 0, 0, 0);
    n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || pc_o !== 32'h102) begin n_fail++; $display("FAIL br_upper got=%b/%b/%h exp=0/1/102", instr_valid_o, fetch_ready_o, pc_o); end
    drive(1, 32'hEEEE_5678, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o !== 32'h5678_0613 || instr_valid_o !== 1'b1 || pc_o !== 32'h102) begin n_fail++; $display("FAIL br_instr got=%h/%b/%h exp=56780613/1/102", instr_aligned_o, instr_valid_o, pc_o); end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h106) begin n_fail++; $display("FAIL br_next got=%h exp=106", pc_o); end
  endtask

  task automatic test_branch_during_m16();
    do_reset();
    drive(1, 32'h4585_4501, 1, 0, 0, 0, 0);
    drive(0, 32'h0, 1, 1, 32'h300, 1, 32'h200);
    n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL brm16_cycle got=%b/%b exp=0/0", instr_valid_o, fetch_ready_o); end
    drive(1, 32'h0000_0013, 1, 0, 0, 0, 0);
    n_tests++; if (instr_aligned_o !== 32'h13 || instr_valid_o !== 1'b1 || pc_o !== 32'h300) begin n_fail++; $display("FAIL brm16_instr got=%h/%b/%h exp=13/1/300", instr_aligned_o, instr_valid_o, pc_o); end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h304) begin n_fail++; $display("FAIL brm16_hwlp_dropped got=%h exp=304", pc_o); end
  endtask

  task automatic test_hwlp();
    logic [31:0] exp_pc;
    exp_pc = HWLP_EN ? 32'h200 : 32'h84;
    do_reset();
    drive(1, 32'h0000_0013, 0, 0, 0, 1, 32'h200);
    n_tests++; if (pc_o !== 32'h80 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL hwlp_hold got=%h/%b exp=80/1", pc_o, instr_valid_o); end
    drive(1, 32'h0000_0013, 1, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL hwlp_pc got=%h exp=%h", pc_o, exp_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    drive(1, 32'h4585_4501, 1, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", pc_o); end
    drive(0, 32'h0, 1, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'hFFFF_FFFE || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_pc1 got=%h/%b exp=fffffffe/1", pc_o, instr_valid_o); end
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pc2 got=%h exp=0", pc_o); end
  endtask

  // Model: program is a halfword memory; faddr is the word the prefetcher presents.
  // An instruction is available once every word it touches is presented or already consumed.
  task automatic test_random();
    logic [31:0] pc, faddr, paddr, len, first_w, last_w, exp_instr, tgt;
    logic [15:0] h0;
    logic        pend, hold, exp_valid, exp_ready, accept, consume;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
    end
    do_reset();
    pc = 32'h80; faddr = 32'h80; pend = 1'b0; paddr = 32'h0; hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fetch_valid_i    = hold || ($urandom_range(0, 9) < 7);
      fetch_rdata_i    = fetch_valid_i ? {hw(faddr + 32'd2), hw(faddr)} : $urandom;
      if_valid_i       = ($urandom_range(0, 9) < 8);
      branch_i         = ($urandom_range(0, 39) == 0);
      branch_addr_i    = $urandom & 32'hFFFF_FFFE;
      hwlp_update_pc_i = ($urandom_range(0, 29) == 0);
      hwlp_addr_i      = $urandom & 32'hFFFF_FFFE;
      h0        = hw(pc);
      len       = (h0[1:0] == 2'b11) ? 32'd4 : 32'd2;
      first_w   = pc & 32'hFFFF_FFFC;
      last_w    = (pc + len - 32'd2) & 32'hFFFF_FFFC;
      exp_instr = {hw(pc + 32'd2), h0};
      exp_valid = !branch_i && ((last_w == faddr - 32'd4) || (last_w == faddr && fetch_valid_i));
      exp_ready = !branch_i && ((last_w == faddr) || (first_w == faddr));
      #1;
      n_tests++; if (pc_o !== pc) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", c, pc_o, pc); end
      n_tests++; if (instr_valid_o !== exp_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, instr_valid_o, exp_valid); end
      n_tests++; if (fetch_ready_o !== exp_ready) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, fetch_ready_o, exp_ready); end
      if (exp_valid) begin
        n_tests++; if (instr_compressed_o !== (len == 32'd2)) begin n_fail++; $display("FAIL rand_comp cyc=%0d got=%b exp=%b", c, instr_compressed_o, len == 32'd2); end
        n_tests++;
        if ((len == 32'd4 && instr_aligned_o !== exp_instr) || (len == 32'd2 && instr_aligned_o[15:0] !== h0)) begin
          n_fail++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h len=%0d", c, instr_aligned_o, exp_instr, len);
        end
      end
      accept  = exp_valid && if_valid_i;
      consume = fetch_valid_i && exp_ready && (accept || (first_w == faddr && last_w != faddr));
      hold    = fetch_valid_i && !consume;
      if (branch_i) begin
        pc = branch_addr_i; faddr = branch_addr_i & 32'hFFFF_FFFC; pend = 1'b0; hold = 1'b0;
      end else begin
        if (consume) faddr = faddr + 32'd4;
        if (accept) begin
          if (HWLP_EN && (hwlp_update_pc_i || pend)) begin
            tgt = hwlp_update_pc_i ? hwlp_addr_i : paddr;
            pc = tgt; faddr = tgt & 32'hFFFF_FFFC; pend = 1'b0; hold = 1'b0;
          end else begin
            pc = pc + len;
          end
        end else if (HWLP_EN && hwlp_update_pc_i) begin
          pend = 1'b1; paddr = hwlp_addr_i;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned32();
    test_straddle();
    test_two_compressed();
    test_branch_misaligned();
    test_branch_during_m16();
    test_hwlp();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
